// File: rtl/simd_compute_array_if.sv
// Beat stream into and result stream out of simd_compute_array.
// The master side issues operand beats and consumes results; the slave is the array.
interface simd_compute_array_if #(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_BITS   = 4,
  parameter int FUNCTION_BITS = 4
);
  logic                            in_valid;
  logic                            in_ready;
  logic [OPCODE_BITS-1:0]          opcode;
  logic [FUNCTION_BITS-1:0]        fn;
  logic                            reduce_en;
  logic                            in_first;
  logic                            in_last;
  logic [NUM_LANES*DATA_WIDTH-1:0] data_in0;
  logic [NUM_LANES*DATA_WIDTH-1:0] data_in1;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;
  logic [NUM_LANES*DATA_WIDTH-1:0] data_out;

  modport master (
    output in_valid, opcode, fn, reduce_en, in_first, in_last, data_in0, data_in1, out_ready,
    input  in_ready, out_valid, out_last, data_out
  );

  modport slave (
    input  in_valid, opcode, fn, reduce_en, in_first, in_last, data_in0, data_in1, out_ready,
    output in_ready, out_valid, out_last, data_out
  );
endinterface

// File: rtl/simd_compute_array.sv
// Two-stage multi-lane fixed-point SIMD array with valid/ready flow control and
// per-lane accumulators for multi-beat reductions.
module simd_compute_array #(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int FRAC_BITS     = 8,
  parameter int OPCODE_BITS   = 4,
  parameter int FUNCTION_BITS = 4
) (
  input logic                 clk,
  input logic                 reset,
  simd_compute_array_if.slave bus
);
  localparam int VW = NUM_LANES * DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] SAT_HI = {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

  function automatic logic signed [PW-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    if (v > SAT_HI) begin
      r = SAT_HI[DATA_WIDTH-1:0];
    end else if (v < SAT_LO) begin
      r = SAT_LO[DATA_WIDTH-1:0];
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  // chain=1 on non-first reduction beats: operand B becomes the accumulator,
  // except MACC, which always multiplies by data_in1 and adds the accumulator.
  function automatic logic [DATA_WIDTH-1:0] lane_op(
    input logic [OPCODE_BITS-1:0]   op,
    input logic [FUNCTION_BITS-1:0] f,
    input logic                     chain,
    input logic [DATA_WIDTH-1:0]    a,
    input logic [DATA_WIDTH-1:0]    b_in,
    input logic [DATA_WIDTH-1:0]    acc_in
  );
    logic [DATA_WIDTH-1:0] b_sel;
    logic [DATA_WIDTH-1:0] b_mul;
    logic signed [PW-1:0]  ax;
    logic signed [PW-1:0]  bx;
    logic signed [PW-1:0]  cx;
    logic signed [PW-1:0]  scaled;
    logic [DATA_WIDTH-1:0] r;
    logic                  is_macc;
    is_macc = (op == OPCODE_BITS'(0)) && (f == FUNCTION_BITS'(3));
    b_sel   = chain ? acc_in : b_in;
    b_mul   = is_macc ? b_in : b_sel;
    ax      = sext(a);
    bx      = sext(b_sel);
    cx      = chain ? sext(acc_in) : {PW{1'b0}};
    scaled  = (ax * sext(b_mul)) >>> FRAC_BITS;
    r       = {DATA_WIDTH{1'b0}};
    case (op)
      OPCODE_BITS'(0): begin
        case (f)
          FUNCTION_BITS'(0): r = sat(ax + bx);
          FUNCTION_BITS'(1): r = sat(ax - bx);
          FUNCTION_BITS'(2): r = sat(scaled);
          FUNCTION_BITS'(3): r = sat(cx + scaled);
          default:           r = {DATA_WIDTH{1'b0}};
        endcase
      end
      OPCODE_BITS'(2): begin
        case (f)
          FUNCTION_BITS'(0): r = ($signed(a) > $signed(b_sel)) ? a : b_sel;
          FUNCTION_BITS'(1): r = ($signed(a) < $signed(b_sel)) ? a : b_sel;
          FUNCTION_BITS'(2): r = (a == b_sel) ? {{(DATA_WIDTH - 1){1'b0}}, 1'b1} : {DATA_WIDTH{1'b0}};
          default:           r = {DATA_WIDTH{1'b0}};
        endcase
      end
      OPCODE_BITS'(3): begin
        case (f)
          FUNCTION_BITS'(0): r = a[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : a;
          default:           r = {DATA_WIDTH{1'b0}};
        endcase
      end
      default: r = {DATA_WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  logic                     s1_valid_q,  s1_valid_d;
  logic [OPCODE_BITS-1:0]   s1_opcode_q, s1_opcode_d;
  logic [FUNCTION_BITS-1:0] s1_fn_q,     s1_fn_d;
  logic                     s1_reduce_q, s1_reduce_d;
  logic                     s1_first_q,  s1_first_d;
  logic                     s1_last_q,   s1_last_d;
  logic [VW-1:0]            s1_a_q,      s1_a_d;
  logic [VW-1:0]            s1_b_q,      s1_b_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q,  out_last_d;
  logic [VW-1:0]            data_out_q,  data_out_d;
  logic [VW-1:0]            acc_q,       acc_d;
  logic [VW-1:0]            result_s;
  logic                     chain_s;
  logic                     advance_s;

  assign advance_s     = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = reset || advance_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.data_out  = data_out_q;
  assign chain_s       = s1_reduce_q && !s1_first_q;

  // Per-lane datapath evaluated on the S1 contents.
  always_comb begin
    result_s = {VW{1'b0}};
    for (int l = 0; l < NUM_LANES; l++) begin
      result_s[l*DATA_WIDTH +: DATA_WIDTH] = lane_op(
        s1_opcode_q, s1_fn_q, chain_s,
        s1_a_q[l*DATA_WIDTH +: DATA_WIDTH],
        s1_b_q[l*DATA_WIDTH +: DATA_WIDTH],
        acc_q[l*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Next state for both stages and the accumulators; everything holds when stalled.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_opcode_d = s1_opcode_q;
    s1_fn_d     = s1_fn_q;
    s1_reduce_d = s1_reduce_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    data_out_d  = data_out_q;
    acc_d       = acc_q;
    if (advance_s) begin
      s1_valid_d  = bus.in_valid;
      s1_opcode_d = bus.opcode;
      s1_fn_d     = bus.fn;
      s1_reduce_d = bus.reduce_en;
      s1_first_d  = bus.in_first;
      s1_last_d   = bus.in_last;
      s1_a_d      = bus.data_in0;
      s1_b_d      = bus.data_in1;
      if (s1_valid_q) begin
        // Silent reduction beats update the accumulator but never raise out_valid.
        out_valid_d = !s1_reduce_q || s1_last_q;
        out_last_d  = s1_reduce_q && s1_last_q;
        data_out_d  = result_s;
        if (s1_reduce_q) begin
          acc_d = result_s;
        end else begin
          acc_d = acc_q;
        end
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_opcode_q <= {OPCODE_BITS{1'b0}};
      s1_fn_q     <= {FUNCTION_BITS{1'b0}};
      s1_reduce_q <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_a_q      <= {VW{1'b0}};
      s1_b_q      <= {VW{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      data_out_q  <= {VW{1'b0}};
      acc_q       <= {VW{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_opcode_q <= s1_opcode_d;
      s1_fn_q     <= s1_fn_d;
      s1_reduce_q <= s1_reduce_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      data_out_q  <= data_out_d;
      acc_q       <= acc_d;
    end
  end
endmodule

// File: tb/tb_simd_compute_array.sv
// Bench for simd_compute_array: directed beats with literal expectations plus a
// randomized stream checked every cycle against a behavioural lane model.
module tb_simd_compute_array;
  localparam int NL = 4;
  localparam int DW = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  logic rst_seen = 1'b0;

  always #5 clk = ~clk;

  simd_compute_array_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .OPCODE_BITS(4), .FUNCTION_BITS(4)) bus_if ();

  simd_compute_array #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .FRAC_BITS(8), .OPCODE_BITS(4), .FUNCTION_BITS(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  res_t         exp_q[$];
  res_t         got_q[$];
  int           acc_m[NL];
  int           n_vec = 0;
  int           n_miss = 0;
  logic         held = 1'b0;
  logic [127:0] held_data;
  logic         held_last;
  bit           rnd_done;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [127:0] v4(input int l0, input int l1, input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic int sat(input longint v);
    if (v > SMAX) return int'(SMAX);
    if (v < SMIN) return int'(SMIN);
    return int'(v);
  endfunction

  // Lane semantics straight from the operation table.
  function automatic int ref_lane(input int op, input int fn, input bit ch,
                                  input int a, input int b, input int accv);
    longint bb;
    longint at;
    bb = ch ? longint'(accv) : longint'(b);
    at = ch ? longint'(accv) : 64'sd0;
    if (op == 0 && fn == 0) return sat(longint'(a) + bb);
    if (op == 0 && fn == 1) return sat(longint'(a) - bb);
    if (op == 0 && fn == 2) return sat((longint'(a) * bb) >>> 8);
    if (op == 0 && fn == 3) return sat(at + ((longint'(a) * longint'(b)) >>> 8));
    if (op == 2 && fn == 0) return (longint'(a) > bb) ? a : int'(bb);
    if (op == 2 && fn == 1) return (longint'(a) < bb) ? a : int'(bb);
    if (op == 2 && fn == 2) return (longint'(a) == bb) ? 1 : 0;
    if (op == 3 && fn == 0) return (a < 0) ? 0 : a;
    return 0;
  endfunction

  task automatic model_beat();
    res_t r;
    bit   red;
    bit   ch;
    int   v;
    red = bus_if.reduce_en;
    ch  = red && !bus_if.in_first;
    r.data = '0;
    for (int l = 0; l < NL; l++) begin
      v = ref_lane(int'(bus_if.opcode), int'(bus_if.fn), ch,
                   int'($signed(bus_if.data_in0[l*DW +: DW])),
                   int'($signed(bus_if.data_in1[l*DW +: DW])), acc_m[l]);
      if (red) acc_m[l] = v;
      r.data[l*DW +: DW] = v;
    end
    r.last = red && bus_if.in_last;
    if (!red || bus_if.in_last) exp_q.push_back(r);
  endtask

  always @(posedge clk) rst_seen <= reset;

  // Single compare process: checks outputs against the model on every cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      for (int l = 0; l < NL; l++) acc_m[l] = 0;
      held = 1'b0;
      chk1("rst_in_ready", bus_if.in_ready, 1'b1);
      if (rst_seen) begin
        chk1("rst_out_valid", bus_if.out_valid, 1'b0);
        chk1("rst_out_last", bus_if.out_last, 1'b0);
        chk("rst_data_out", bus_if.data_out, 128'd0);
      end
    end else begin
      chk1("in_ready", bus_if.in_ready, !bus_if.out_valid || bus_if.out_ready);
      if (bus_if.out_valid) begin
        if (held) begin
          chk("hold_data", bus_if.data_out, held_data);
          chk1("hold_last", bus_if.out_last, held_last);
        end
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL spurious_out: got %h expected no output", bus_if.data_out);
        end else begin
          chk("data_out", bus_if.data_out, exp_q[0].data);
          chk1("out_last", bus_if.out_last, exp_q[0].last);
          if (bus_if.out_ready) begin
            got_q.push_back('{data: bus_if.data_out, last: bus_if.out_last});
            void'(exp_q.pop_front());
          end
        end
      end
      held      = bus_if.out_valid && !bus_if.out_ready;
      held_data = bus_if.data_out;
      held_last = bus_if.out_last;
      if (bus_if.in_valid && bus_if.in_ready) model_beat();
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
  task automatic drive(input int op, input int fn, input bit red, input bit first, input bit last,
                       input logic [127:0] a, input logic [127:0] b);
    int guard;
    guard = 0;
    bus_if.opcode    = 4'(op);
    bus_if.fn        = 4'(fn);
    bus_if.reduce_en = red;
    bus_if.in_first  = first;
    bus_if.in_last   = last;
    bus_if.data_in0  = a;
    bus_if.data_in1  = b;
    bus_if.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus_if.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_vec++;
      n_miss++;
      $display("FAIL drive_timeout: in_ready stuck at %b expected 1", bus_if.in_ready);
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int guard;
    guard = 0;
    while (got_q.size() < n && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (got_q.size() < n) begin
      n_vec++;
      n_miss++;
      $display("FAIL out_timeout: got %0d results expected %0d", got_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_lane();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 600)) - 300;
      1: return int'($urandom());
      2: return ($urandom_range(0, 1) == 0) ? 32'h7fffffff : 32'h80000000;
      default: return int'($urandom_range(0, 8)) * 32'sh100 - 32'sh400;
    endcase
  endfunction

  function automatic logic [127:0] rand_vec();
    return v4(rand_lane(), rand_lane(), rand_lane(), rand_lane());
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.opcode    = 4'd0;
    bus_if.fn        = 4'd0;
    bus_if.reduce_en = 1'b0;
    bus_if.in_first  = 1'b0;
    bus_if.in_last   = 1'b0;
    bus_if.data_in0  = 128'd0;
    bus_if.data_in1  = 128'd0;
    bus_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // ADD with saturation and two-cycle latency
    bus_if.opcode = 4'd0; bus_if.fn = 4'd0; bus_if.reduce_en = 1'b0;
    bus_if.in_first = 1'b0; bus_if.in_last = 1'b0;
    bus_if.data_in0 = v4(1, 2, 3, 32'h7fffffff);
    bus_if.data_in1 = v4(10, 20, 30, 1);
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    chk1("add_lat1_valid", bus_if.out_valid, 1'b0);
    @(negedge clk);
    chk1("add_lat2_valid", bus_if.out_valid, 1'b1);
    chk("add_data", bus_if.data_out, v4(11, 22, 33, 32'h7fffffff));
    chk1("add_last", bus_if.out_last, 1'b0);
    @(posedge clk);
    #1;

    // MUL rescale, floor and saturation both ways
    got_q.delete();
    drive(0, 2, 1'b0, 1'b0, 1'b0, v4(32'h180, -1, 32'h7fffffff, 32'h80000000),
          v4(32'h200, 1, 32'h7fffffff, 32'h7fffffff));
    wait_got(1);
    chk("mul_data", got_q[0].data, v4(32'h300, -1, 32'h7fffffff, 32'h80000000));

    // 3-beat MAX reduction
    got_q.delete();
    drive(2, 0, 1'b1, 1'b1, 1'b0, v4(5, -1, 0, 0), v4(0, 0, 0, 0));
    drive(2, 0, 1'b1, 1'b0, 1'b0, v4(-2, -7, 0, 0), v4(99, 99, 99, 99));
    drive(2, 0, 1'b1, 1'b0, 1'b1, v4(9, -3, 0, 0), v4(99, 99, 99, 99));
    wait_got(1);
    chk("max_red_data", got_q[0].data, v4(9, 0, 0, 0));
    chk1("max_red_last", got_q[0].last, 1'b1);

    // 4-beat MACC reduction streamed back-to-back
    got_q.delete();
    for (int i = 0; i < 4; i++)
      drive(0, 3, 1'b1, i == 0, i == 3, v4(32'h100, 32'h100, 32'h100, 32'h100),
            v4(32'h100, 32'h100, 32'h100, 32'h100));
    wait_got(1);
    chk("macc_red_data", got_q[0].data, v4(32'h400, 32'h400, 32'h400, 32'h400));
    chk1("macc_red_last", got_q[0].last, 1'b1);

    // Same MACC with an ADD beat interleaved mid-stream
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) drive(0, 0, 1'b0, 1'b0, 1'b0, v4(1, 2, 3, 4), v4(10, 10, 10, 10));
      drive(0, 3, 1'b1, i == 0, i == 3, v4(32'h100, 32'h100, 32'h100, 32'h100),
            v4(32'h100, 32'h100, 32'h100, 32'h100));
    end
    wait_got(2);
    chk("interleave_add", got_q[0].data, v4(11, 12, 13, 14));
    chk1("interleave_add_last", got_q[0].last, 1'b0);
    chk("interleave_macc", got_q[1].data, v4(32'h400, 32'h400, 32'h400, 32'h400));

    // Backpressure: three beats against five stalled cycles
    got_q.delete();
    bus_if.out_ready = 1'b0;
    fork
      for (int k = 1; k <= 3; k++) drive(0, 0, 1'b0, 1'b0, 1'b0, v4(k, k, k, k), v4(0, 0, 0, 0));
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk1("bp_in_ready_low", bus_if.in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus_if.out_ready = 1'b1;
      end
    join
    wait_got(3);
    for (int k = 0; k < 3; k++) chk("bp_order", got_q[k].data, v4(k + 1, k + 1, k + 1, k + 1));

    // Reset on the 2nd reduction beat, then a fresh one-beat reduction
    drive(0, 0, 1'b1, 1'b1, 1'b0, v4(100, 100, 100, 100), v4(1, 1, 1, 1));
    bus_if.reduce_en = 1'b1; bus_if.in_first = 1'b0; bus_if.in_last = 1'b1;
    bus_if.data_in0 = v4(50, 50, 50, 50);
    bus_if.in_valid = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bus_if.in_valid = 1'b0;
    got_q.delete();
    drive(0, 0, 1'b1, 1'b1, 1'b1, v4(7, 7, 7, 7), v4(3, 3, 3, 3));
    wait_got(1);
    chk("post_rst_one_beat", got_q[0].data, v4(10, 10, 10, 10));
    chk1("post_rst_last", got_q[0].last, 1'b1);

    // Non-first beat straight after reset chains from a zero accumulator
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    drive(0, 0, 1'b1, 1'b0, 1'b1, v4(5, 5, 5, 5), v4(99, 99, 99, 99));
    wait_got(1);
    chk("post_rst_nonfirst", got_q[0].data, v4(5, 5, 5, 5));

    // Randomized stream with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #0;
          drive(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : 0,
                int'($urandom_range(0, 4)),
                bit'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, rand_vec(), rand_vec());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus_if.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus_if.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
